// File: rtl/clkdiv_prog.sv
// clkdiv_prog: runtime-programmable single-counter clock divider with tick strobe and glitch-free divisor updates
module clkdiv_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_clk,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div
);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  logic [WIDTH-1:0] cnt_q, cnt_d, cur_q, cur_d, pend_q, pend_d;
  logic [WIDTH-1:0] load_val, next_div, half;
  logic clk_q, clk_d, tick_q, tick_d, pend_v_q, pend_v_d, wrap;
  assign load_val = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
  assign next_div = div_load ? load_val : pend_v_q ? pend_q : cur_q;
  assign half     = cur_q - (cur_q >> 1);
  assign wrap     = en && (cnt_q == cur_q - WIDTH'(1));
  // next state: restart beats freeze beats wrap beats the high-to-low edge; loads land at period boundaries
  always_comb begin
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    cur_d    = cur_q;
    pend_d   = div_load ? load_val : pend_q;
    pend_v_d = pend_v_q | div_load;
    if (restart) begin
      cnt_d    = '0;
      clk_d    = 1'b0;
      cur_d    = next_div;
      pend_v_d = 1'b0;
    end else if (wrap) begin
      cnt_d    = '0;
      clk_d    = 1'b1;
      tick_d   = 1'b1;
      cur_d    = next_div;
      pend_v_d = 1'b0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
      clk_d = (cnt_q == half - WIDTH'(1)) ? 1'b0 : clk_q;
    end
  end
  // state registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      cur_q    <= DEF;
      pend_q   <= DEF;
      pend_v_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end
  assign div_clk = clk_q;
  assign tick    = tick_q;
  assign cur_div = cur_q;
endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: random and directed checks of two divider instances against a period/phase reference model
module tb_clkdiv_prog;
  logic clk = 1'b0, reset = 1'b0, en = 1'b0, restart = 1'b0, div_load = 1'b0;
  logic [7:0] div_in = '0;
  logic dc0, tk0, dc1, tk1;
  logic [7:0] cd0;
  logic [3:0] cd1;
  int checks = 0, failures = 0;
  int m_pos[2], m_n[2], m_pend[2];
  bit m_first[2], m_pv[2], m_tick[2];
  always #5 clk = ~clk;
  clkdiv_prog #(.WIDTH(8), .DEFAULT_DIV(4)) u0 (
    .clk(clk), .reset(reset), .en(en), .restart(restart), .div_in(div_in),
    .div_load(div_load), .div_clk(dc0), .tick(tk0), .cur_div(cd0));
  clkdiv_prog #(.WIDTH(4), .DEFAULT_DIV(15)) u1 (
    .clk(clk), .reset(reset), .en(en), .restart(restart), .div_in(div_in[3:0]),
    .div_load(div_load), .div_clk(dc1), .tick(tk1), .cur_div(cd1));
  function automatic int clampv(input int k, input int d);
    int v;
    v = k ? (d & 15) : (d & 255);
    return v < 2 ? 2 : v;
  endfunction
  function automatic int exp_clk(input int k);
    return (!m_first[k] && m_pos[k] < m_n[k] - m_n[k] / 2) ? 1 : 0;
  endfunction
  // reference: position within the period plus "first period after reset/restart" flag
  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_pos[k] = 0; m_first[k] = 1; m_n[k] = k ? 15 : 4; m_pv[k] = 0; m_tick[k] = 0; m_pend[k] = 0;
      end else if (restart) begin
        m_n[k] = div_load ? clampv(k, div_in) : m_pv[k] ? m_pend[k] : m_n[k];
        m_pv[k] = 0; m_pos[k] = 0; m_first[k] = 1; m_tick[k] = 0;
      end else if (en && m_pos[k] == m_n[k] - 1) begin
        m_n[k] = div_load ? clampv(k, div_in) : m_pv[k] ? m_pend[k] : m_n[k];
        m_pv[k] = 0; m_pos[k] = 0; m_first[k] = 0; m_tick[k] = 1;
      end else begin
        m_tick[k] = 0;
        if (en) m_pos[k]++;
        if (div_load) begin m_pend[k] = clampv(k, div_in); m_pv[k] = 1; end
      end
    end
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cmp_all();
    chk("div_clk0", int'(dc0), exp_clk(0));
    chk("tick0", int'(tk0), int'(m_tick[0]));
    chk("cur_div0", int'(cd0), m_n[0]);
    chk("div_clk1", int'(dc1), exp_clk(1));
    chk("tick1", int'(tk1), int'(m_tick[1]));
    chk("cur_div1", int'(cd1), m_n[1]);
  endtask
  task automatic step(input logic e, input logic r, input logic l, input logic [7:0] d);
    en = e; restart = r; div_load = l; div_in = d;
    @(negedge clk);
    cmp_all();
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_clk", int'(dc0), 0);
    chk("rst_tick", int'(tk0), 0);
    chk("rst_cur0", int'(cd0), 4);
    chk("rst_cur1", int'(cd1), 15);
    cmp_all();
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0);
      chk("first_rise_tick", int'(tk0), i == 4 ? 1 : 0);
      chk("first_rise_clk", int'(dc0), i == 4 ? 1 : 0);
    end
    repeat (5) step(1, 0, 0, 0);
    step(1, 0, 1, 8'd5);
    chk("load_keeps_cur", int'(cd0), 4);
    repeat (20) step(1, 0, 0, 0);
    chk("load5_applied", int'(cd0), 5);
    step(1, 0, 1, 8'd0);
    step(1, 0, 1, 8'd1);
    repeat (12) step(1, 0, 0, 0);
    chk("clamp_to_2", int'(cd0), 2);
    repeat (6) step(1, 0, 0, 0);
    step(1, 0, 1, 8'd9);
    for (int i = 0; i < 12; i++) step(i >= 2 && i < 5 ? 1'b0 : 1'b1, 0, 0, 0);
    step(1, 0, 1, 8'd7);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("restart_clk", int'(dc0), 0);
    chk("restart_cur", int'(cd0), 7);
    repeat (16) step(1, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_clk", int'(dc0), 0);
    chk("async_tick", int'(tk0), 0);
    chk("async_cur", int'(cd0), 4);
    cmp_all();
    @(negedge clk);
    cmp_all();
    reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 10, 8'(d));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
